// File: rtl/register_file.sv
// 16 x 16-bit general-purpose register file. It has one synchronous write port and two
// combinational read ports, and it does not bypass writes to the read ports.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_write_en,
  input  logic [ADDR_WIDTH-1:0] reg_write_dest,
  input  logic [DATA_WIDTH-1:0] reg_write_data,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
  output logic [DATA_WIDTH-1:0] reg_read_data_1,
  input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
  output logic [DATA_WIDTH-1:0] reg_read_data_2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (reg_write_en) begin
      regs_d[reg_write_dest] = reg_write_data;
    end
  end

  // Active-low rst clears every entry asynchronously and also discards any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    reg_read_data_1 = regs_q[reg_read_addr_1];
    reg_read_data_2 = regs_q[reg_read_addr_2];
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file. It covers reset, read-back, a full fill,
// write-enable gating, read-during-write and an asynchronous reset in the middle of a write.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        reg_write_en;
  logic [3:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [3:0]  reg_read_addr_1;
  logic [15:0] reg_read_data_1;
  logic [3:0]  reg_read_addr_2;
  logic [15:0] reg_read_data_2;

  int tests;
  int failed;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .reg_write_en    (reg_write_en),
    .reg_write_dest  (reg_write_dest),
    .reg_write_data  (reg_write_data),
    .reg_read_addr_1 (reg_read_addr_1),
    .reg_read_data_1 (reg_read_data_1),
    .reg_read_addr_2 (reg_read_addr_2),
    .reg_read_data_2 (reg_read_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_reg(input logic [3:0] dest, input logic [15:0] data);
    @(negedge clk);
    reg_write_en   = 1'b1;
    reg_write_dest = dest;
    reg_write_data = data;
    @(posedge clk);
    #1;
    reg_write_en   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    reg_read_addr_1 = 4'd9;
    reg_read_addr_2 = 4'd0;
    #1;
    tests++;
    if (reg_read_data_1 !== 16'h0000 || reg_read_data_2 !== 16'h0000) begin
      failed++;
      $display("FAIL reset_during: got %h/%h expected 0000/0000", reg_read_data_1, reg_read_data_2);
    end
    #7;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      reg_read_addr_1 = 4'(i);
      reg_read_addr_2 = 4'(i);
      #40;
      tests++;
      if (reg_read_data_1 !== 16'h0000 || reg_read_data_2 !== 16'h0000) begin
        failed++;
        $display("FAIL reset_sweep[%0d]: got %h/%h expected 0000/0000", i, reg_read_data_1, reg_read_data_2);
      end
    end
  endtask

  task automatic test_write_read();
    write_reg(4'd3, 16'hBEEF);
    reg_read_addr_1 = 4'd3;
    reg_read_addr_2 = 4'd4;
    #1;
    tests++;
    if (reg_read_data_1 !== 16'hBEEF) begin
      failed++;
      $display("FAIL write_read_p1: got %h expected beef", reg_read_data_1);
    end
    tests++;
    if (reg_read_data_2 !== 16'h0000) begin
      failed++;
      $display("FAIL write_read_p2: got %h expected 0000", reg_read_data_2);
    end
  endtask

  task automatic test_full_fill();
    logic [15:0] exp1, exp2;
    for (int i = 0; i < 16; i++) write_reg(4'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 16; i++) begin
      reg_read_addr_1 = 4'(i);
      reg_read_addr_2 = 4'(15 - i);
      exp1 = 16'h1000 + 16'(i);
      exp2 = 16'h1000 + 16'(15 - i);
      #1;
      tests++;
      if (reg_read_data_1 !== exp1 || reg_read_data_2 !== exp2) begin
        failed++;
        $display("FAIL full_fill[%0d]: got %h/%h expected %h/%h", i, reg_read_data_1, reg_read_data_2, exp1, exp2);
      end
    end
  endtask

  task automatic test_we_low();
    write_reg(4'd5, 16'h1234);
    @(negedge clk);
    reg_write_en   = 1'b0;
    reg_write_dest = 4'd5;
    reg_write_data = 16'hFFFF;
    repeat (4) @(posedge clk);
    #1;
    reg_read_addr_1 = 4'd5;
    reg_read_addr_2 = 4'd5;
    #1;
    tests++;
    if (reg_read_data_1 !== 16'h1234 || reg_read_data_2 !== 16'h1234) begin
      failed++;
      $display("FAIL we_low: got %h/%h expected 1234/1234", reg_read_data_1, reg_read_data_2);
    end
  endtask

  task automatic test_same_cycle();
    write_reg(4'd7, 16'h0001);
    @(negedge clk);
    reg_read_addr_1 = 4'd7;
    reg_read_addr_2 = 4'd7;
    reg_write_en    = 1'b1;
    reg_write_dest  = 4'd7;
    reg_write_data  = 16'h00A5;
    #3;
    tests++;
    if (reg_read_data_1 !== 16'h0001 || reg_read_data_2 !== 16'h0001) begin
      failed++;
      $display("FAIL same_cycle_before: got %h/%h expected 0001/0001", reg_read_data_1, reg_read_data_2);
    end
    @(posedge clk);
    #1;
    reg_write_en = 1'b0;
    tests++;
    if (reg_read_data_1 !== 16'h00A5 || reg_read_data_2 !== 16'h00A5) begin
      failed++;
      $display("FAIL same_cycle_after: got %h/%h expected 00a5/00a5", reg_read_data_1, reg_read_data_2);
    end
  endtask

  task automatic test_async_reset();
    write_reg(4'd2, 16'h5A5A);
    write_reg(4'd12, 16'hC3C3);
    @(negedge clk);
    reg_write_en   = 1'b1;
    reg_write_dest = 4'd2;
    reg_write_data = 16'h7777;
    reg_read_addr_1 = 4'd2;
    reg_read_addr_2 = 4'd12;
    #1;
    tests++;
    if (reg_read_data_1 !== 16'h5A5A || reg_read_data_2 !== 16'hC3C3) begin
      failed++;
      $display("FAIL async_preload: got %h/%h expected 5a5a/c3c3", reg_read_data_1, reg_read_data_2);
    end
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (reg_read_data_1 !== 16'h0000 || reg_read_data_2 !== 16'h0000) begin
      failed++;
      $display("FAIL async_immediate: got %h/%h expected 0000/0000", reg_read_data_1, reg_read_data_2);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      reg_read_addr_1 = 4'(i);
      reg_read_addr_2 = 4'(15 - i);
      #1;
      tests++;
      if (reg_read_data_1 !== 16'h0000 || reg_read_data_2 !== 16'h0000) begin
        failed++;
        $display("FAIL async_sweep[%0d]: got %h/%h expected 0000/0000", i, reg_read_data_1, reg_read_data_2);
      end
    end
    @(negedge clk);
    reg_write_en = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reg_read_addr_1 = 4'd2;
    reg_read_addr_2 = 4'd12;
    #1;
    tests++;
    if (reg_read_data_1 !== 16'h0000 || reg_read_data_2 !== 16'h0000) begin
      failed++;
      $display("FAIL async_write_lost: got %h/%h expected 0000/0000", reg_read_data_1, reg_read_data_2);
    end
  endtask

  initial begin
    tests           = 0;
    failed          = 0;
    rst             = 1'b0;
    reg_write_en    = 1'b0;
    reg_write_dest  = '0;
    reg_write_data  = '0;
    reg_read_addr_1 = '0;
    reg_read_addr_2 = '0;
    test_reset();
    test_write_read();
    test_full_fill();
    test_we_low();
    test_same_cycle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- General-purpose register file for the 16-bit CPU datapath: 16 registers x 16 bits.
- One synchronous write port and two independent combinational read ports.
- Read port 1 feeds ALU operand A; read port 2 feeds ALU operand B / store data.
- The write port is driven from the writeback stage.

Parameters:
- DATA_WIDTH, 16, width of each register and of the data ports.
- ADDR_WIDTH, 4, register address width. Number of registers is 2**ADDR_WIDTH (16).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears every register immediately; released synchronously by the system.
- reg_write_en  input  1  write enable, active high, sampled on the rising clk edge.
- reg_write_dest  input  ADDR_WIDTH  destination register index for writes.
- reg_write_data  input  DATA_WIDTH  data to write.
- reg_read_addr_1  input  ADDR_WIDTH  read port 1 register index.
- reg_read_data_1  output  DATA_WIDTH  read port 1 data.
- reg_read_addr_2  input  ADDR_WIDTH  read port 2 register index.
- reg_read_data_2  output  DATA_WIDTH  read port 2 data.

Behaviour:
- Storage: 16 registers, R0..R15, each DATA_WIDTH bits. All registers are writable; R0 is NOT hardwired to zero.
- Reset:
  - While rst = 0, all registers are forced to 16'h0000 asynchronously, with no clock needed.
  - Writes are ignored while rst = 0.
  - Both read outputs therefore read 16'h0000 during reset, whatever the read address.
- Write:
  - On a rising clk edge with rst = 1 and reg_write_en = 1, R[reg_write_dest] <= reg_write_data.
  - With reg_write_en = 0, no register changes.
  - Exactly one register is written per cycle.
- Read:
  - Purely combinational, with no clock latency: reg_read_data_1 = R[reg_read_addr_1] and reg_read_data_2 = R[reg_read_addr_2].
  - A new address is reflected at the output in the same cycle.
  - Both ports may address the same register simultaneously; both return the same value.
- Read during write to the same address, in the same cycle:
  - The read returns the OLD contents until the clock edge, then the new value after it.
  - There is no write-to-read bypass; forwarding is handled in the pipeline.
- Addresses are full-range (0..15). There is no out-of-range case and no wrap logic.
- No X propagation: after reset, every output is a defined value for every address.
- Reset mid-operation: asserting rst while reg_write_en = 1 discards the pending write. All registers read 0 immediately.

Test Plan:
- Reset sweep:
  - Stimulus: assert rst = 0 for 10 ns, release. Step reg_read_addr_1 and reg_read_addr_2 together from 0 to 15, one step every 40 ns.
  - Response: both ports read 16'h0000 for every register.
- Write/read back:
  - Stimulus: write R3 <= 16'hBEEF with reg_write_en = 1 for one cycle. Set reg_read_addr_1 = 3 and reg_read_addr_2 = 4.
  - Response: port 1 reads 16'hBEEF, port 2 reads 16'h0000.
- Full fill:
  - Stimulus: write R[i] <= 16'h1000 + i for i = 0..15. Then read port 1 at i and port 2 at 15 - i.
  - Response: port 1 = 16'h1000 + i; port 2 = 16'h1000 + (15 - i). R0 reads 16'h1000, confirming it is writable.
- Write-enable low:
  - Stimulus: with R5 = 16'h1234, drive reg_write_dest = 5, reg_write_data = 16'hFFFF, reg_write_en = 0 for several edges.
  - Response: R5 still reads 16'h1234.
- Same-cycle read/write:
  - Stimulus: with R7 = 16'h0001, both read ports address 7 while writing 16'h00A5 to R7.
  - Response: both ports read 16'h0001 before the edge and 16'h00A5 after it.
- Async reset mid-write:
  - Stimulus: registers loaded with nonzero values. Drop rst mid-cycle with reg_write_en = 1.
  - Response: all registers read 16'h0000 immediately, without a clock edge. The pending write is lost.
